delay_ctrl: RTL and testbench

DELAY_CTRL -- requirements
Module: delay_ctrl

---
 rtl/delay_ctrl_if.sv | 35 +++
 rtl/delay_ctrl.sv | 131 +++++++++++++
 tb/tb_delay_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/delay_ctrl_if.sv
// delay_ctrl_if -- stream/configuration bundle between the upstream pixel
// source, the line-delay controller and the line-delay block.
// master: the side that drives configuration, pixels and delay_val.
// slave : the controller itself.
interface delay_ctrl_if #(
    parameter int IMG_WIDTH  = 8,
    parameter int MEM_AWIDTH = 8
);
    logic [MEM_AWIDTH-1:0] cfg_width;
    logic [MEM_AWIDTH-1:0] cfg_height;
    logic                  cfg_set;
    logic [IMG_WIDTH-1:0]  up_data;
    logic                  up_val;
    logic [MEM_AWIDTH-1:0] dly_cfg_delay;
    logic                  dly_cfg_set;
    logic [IMG_WIDTH-1:0]  dly_data;
    logic                  dly_val;
    logic                  delay_val;
    logic                  win_val;
    logic                  win_last;
    logic                  busy;
    logic                  cfg_err;

    modport master (
        output cfg_width, cfg_height, cfg_set, up_data, up_val, delay_val,
        input  dly_cfg_delay, dly_cfg_set, dly_data, dly_val,
               win_val, win_last, busy, cfg_err
    );

    modport slave (
        input  cfg_width, cfg_height, cfg_set, up_data, up_val, delay_val,
        output dly_cfg_delay, dly_cfg_set, dly_data, dly_val,
               win_val, win_last, busy, cfg_err
    );
endinterface

// File: rtl/delay_ctrl.sv
// delay_ctrl -- configures a line-delay block, forwards the pixel stream to
// it and flags when its tap bus holds a full HEIGHT_NB-row window.
// Optional feature: define DELAY_CTRL_FRAME_CNT_EN to add the 16-bit
// frame_cnt output counting completed frames.
module delay_ctrl #(
    parameter int HEIGHT_NB  = 3,
    parameter int IMG_WIDTH  = 8,
    parameter int MEM_AWIDTH = 8,
    parameter int MEM_DEPTH  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    delay_ctrl_if.slave bus
`ifdef DELAY_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, PRIME, RUN} state_t;

    localparam logic [MEM_AWIDTH-1:0] ONE        = MEM_AWIDTH'(1);
    localparam logic [MEM_AWIDTH-1:0] PRIME_ROWS = MEM_AWIDTH'(HEIGHT_NB - 1);
    localparam logic [MEM_AWIDTH-1:0] MIN_HEIGHT = MEM_AWIDTH'(HEIGHT_NB);
    localparam logic [MEM_AWIDTH-1:0] MAX_WIDTH  = MEM_AWIDTH'(MEM_DEPTH);

    state_t                state;
    logic [MEM_AWIDTH-1:0] width_q;
    logic [MEM_AWIDTH-1:0] height_q;
    logic [MEM_AWIDTH-1:0] col_q;
    logic [MEM_AWIDTH-1:0] row_q;
    logic                  cfg_ok;
    logic                  col_wrap;
    logic                  frame_end;
    logic                  at_bound;
    logic                  fwd;

    // Classify this cycle: config legality, line end, frame end, frame boundary
    always_comb begin
        cfg_ok    = (bus.cfg_width != '0) && (bus.cfg_width <= MAX_WIDTH) &&
                    (bus.cfg_height >= MIN_HEIGHT);
        col_wrap  = bus.delay_val && (col_q == width_q - ONE);
        frame_end = (state == RUN) && col_wrap && (row_q == height_q - ONE);
        // Counters are zero in IDLE/LOAD and at the start of every frame; the
        // last pixel of a frame also counts so a new config can ride on it.
        at_bound  = ((row_q == '0) && (col_q == '0)) || frame_end;
        fwd       = (state == PRIME) || (state == RUN);
    end

    // Control FSM with registered outputs; cfg_set arbitration is last so an
    // accepted configuration overrides the frame-progress updates above it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            width_q           <= '0;
            height_q          <= '0;
            col_q             <= '0;
            row_q             <= '0;
            bus.dly_cfg_delay <= '0;
            bus.dly_cfg_set   <= 1'b0;
            bus.dly_data      <= '0;
            bus.dly_val       <= 1'b0;
            bus.win_val       <= 1'b0;
            bus.win_last      <= 1'b0;
            bus.busy          <= 1'b0;
            bus.cfg_err       <= 1'b0;
`ifdef DELAY_CTRL_FRAME_CNT_EN
            frame_cnt         <= '0;
`endif
        end else begin
            bus.dly_cfg_set <= 1'b0;
            bus.win_val     <= 1'b0;
            bus.win_last    <= 1'b0;
            bus.dly_val     <= bus.up_val && fwd;
            if (bus.up_val && fwd) begin
                bus.dly_data <= IMG_WIDTH'(bus.up_data);
            end

            case (state)
                IDLE: ;
                LOAD: state <= PRIME;
                PRIME: begin
                    if (bus.delay_val) begin
                        if (col_wrap) begin
                            col_q <= '0;
                            row_q <= row_q + ONE;
                            if (row_q + ONE == PRIME_ROWS) begin
                                state <= RUN;
                            end
                        end else begin
                            col_q <= col_q + ONE;
                        end
                    end
                end
                RUN: begin
                    bus.win_val <= bus.delay_val;
                    if (frame_end) begin
                        bus.win_last <= 1'b1;
                        col_q        <= '0;
                        row_q        <= '0;
                        state        <= PRIME;
`ifdef DELAY_CTRL_FRAME_CNT_EN
                        frame_cnt    <= frame_cnt + 16'd1;
`endif
                    end else if (col_wrap) begin
                        col_q <= '0;
                        row_q <= row_q + ONE;
                    end else if (bus.delay_val) begin
                        col_q <= col_q + ONE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (bus.cfg_set) begin
                if (at_bound && cfg_ok) begin
                    width_q           <= bus.cfg_width;
                    height_q          <= bus.cfg_height;
                    col_q             <= '0;
                    row_q             <= '0;
                    bus.dly_cfg_delay <= bus.cfg_width;
                    bus.dly_cfg_set   <= 1'b1;
                    bus.busy          <= 1'b1;
                    bus.cfg_err       <= 1'b0;
                    state             <= LOAD;
                end else begin
                    bus.cfg_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_delay_ctrl.sv
// tb_delay_ctrl -- self-checking bench for delay_ctrl: a directed vector
// table, hand-written frame sequences and a randomized run against a
// pixel-count reference model.
module tb_delay_ctrl;
    localparam int HNB = 3;
    localparam int IW  = 8;
    localparam int AW  = 8;
    localparam int MD  = 15;

    logic clk;
    logic rst_n;
`ifdef DELAY_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    delay_ctrl_if #(.IMG_WIDTH(IW), .MEM_AWIDTH(AW)) dif ();

    delay_ctrl #(
        .HEIGHT_NB (HNB),
        .IMG_WIDTH (IW),
        .MEM_AWIDTH(AW),
        .MEM_DEPTH (MD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (dif)
`ifdef DELAY_CTRL_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a frame is w*h delay_val pulses; the window is full
    // once more than (HNB-1) whole lines have gone past.
    bit         m_active, m_loading, m_err;
    int         m_w, m_h, m_k, m_frames;
    logic       m_cset, m_dval, m_wval, m_wlast;
    logic [7:0] m_cdel, m_ddat;

    task automatic model_reset();
        m_active = 0; m_loading = 0; m_err = 0;
        m_w = 0; m_h = 0; m_k = 0; m_frames = 0;
        m_cset = 0; m_dval = 0; m_wval = 0; m_wlast = 0;
        m_cdel = 0; m_ddat = 0;
    endtask

    task automatic model_update(input logic cs, input logic [7:0] cw, input logic [7:0] ch,
                                input logic uv, input logic [7:0] ud, input logic dv);
        bit fwd;
        bit bound;
        fwd    = m_active && !m_loading;
        m_cset = 0; m_wval = 0; m_wlast = 0;
        m_dval = uv && fwd;
        if (m_dval) m_ddat = ud;
        bound = (m_k == 0);
        if (fwd && dv) begin
            m_k++;
            m_wval = (m_k > (HNB - 1) * m_w);
            if (m_k == m_w * m_h) begin
                m_wlast = 1; m_k = 0; m_frames++; bound = 1;
            end
        end
        m_loading = 0;
        if (cs) begin
            if (bound && cw >= 1 && cw <= MD && ch >= HNB) begin
                m_w = cw; m_h = ch; m_k = 0;
                m_active = 1; m_loading = 1; m_cset = 1; m_cdel = cw; m_err = 0;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic set_in(input logic cs, input logic [7:0] cw, input logic [7:0] ch,
                          input logic uv, input logic [7:0] ud, input logic dv);
        dif.cfg_set = cs; dif.cfg_width = cw; dif.cfg_height = ch;
        dif.up_val = uv; dif.up_data = ud; dif.delay_val = dv;
    endtask

    // One clock: drive at negedge, model follows the posedge, sample at next negedge
    task automatic step(input logic cs, input logic [7:0] cw, input logic [7:0] ch,
                        input logic uv, input logic [7:0] ud, input logic dv);
        set_in(cs, cw, ch, uv, ud, dv);
        @(posedge clk);
        model_update(cs, cw, ch, uv, ud, dv);
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_model();
        chk("dly_cfg_set", dif.dly_cfg_set, m_cset);
        chk("dly_cfg_delay", dif.dly_cfg_delay, m_cdel);
        chk("dly_val", dif.dly_val, m_dval);
        if (m_dval) chk("dly_data", dif.dly_data, m_ddat);
        chk("win_val", dif.win_val, m_wval);
        chk("win_last", dif.win_last, m_wlast);
        chk("busy", dif.busy, m_active);
        chk("cfg_err", dif.cfg_err, m_err);
`ifdef DELAY_CTRL_FRAME_CNT_EN
        chk("frame_cnt", frame_cnt, 32'(m_frames & 16'hFFFF));
`endif
    endtask

    typedef struct {
        logic       cs;
        logic [7:0] cw, ch;
        logic       uv;
        logic [7:0] ud;
        logic       dv;
        logic       e_cset;
        logic [7:0] e_cdel;
        logic       e_dval;
        logic [7:0] e_ddat;
        logic       e_wval, e_wlast, e_busy, e_err;
    } vec_t;

    function automatic vec_t mk(input logic cs, input logic [7:0] cw, input logic [7:0] ch,
                                input logic uv, input logic [7:0] ud, input logic dv,
                                input logic e_cset, input logic [7:0] e_cdel,
                                input logic e_dval, input logic [7:0] e_ddat,
                                input logic e_wval, input logic e_wlast,
                                input logic e_busy, input logic e_err);
        vec_t v;
        v.cs = cs; v.cw = cw; v.ch = ch; v.uv = uv; v.ud = ud; v.dv = dv;
        v.e_cset = e_cset; v.e_cdel = e_cdel; v.e_dval = e_dval; v.e_ddat = e_ddat;
        v.e_wval = e_wval; v.e_wlast = e_wlast; v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    vec_t       tbl [14];
    int         wv_lo, wv_hi, wl_n, wl_at, dmis, spur;
    logic       r_cs, r_uv, r_dv;
    logic [7:0] r_cw, r_ch, r_ud;

    initial begin
        //            cs  cw  ch  uv  ud     dv | cset cdel dval ddat  wv wl busy err
        tbl[0]  = mk(1, 20,  4,  0, 8'h00, 0,   0,  0,  0, 8'h00, 0, 0, 0, 1); // width > depth
        tbl[1]  = mk(1,  0,  4,  0, 8'h00, 0,   0,  0,  0, 8'h00, 0, 0, 0, 1); // width 0
        tbl[2]  = mk(1,  8,  2,  0, 8'h00, 0,   0,  0,  0, 8'h00, 0, 0, 0, 1); // height < taps
        tbl[3]  = mk(0,  0,  0,  1, 8'h33, 1,   0,  0,  0, 8'h00, 0, 0, 0, 1); // IDLE drops pixel
        tbl[4]  = mk(1,  8,  4,  0, 8'h00, 0,   1,  8,  0, 8'h00, 0, 0, 1, 0); // accepted
        tbl[5]  = mk(0,  0,  0,  1, 8'h55, 1,   0,  8,  0, 8'h00, 0, 0, 1, 0); // LOAD drops pixel
        tbl[6]  = mk(0,  0,  0,  1, 8'hA1, 0,   0,  8,  1, 8'hA1, 0, 0, 1, 0); // PRIME forwards
        tbl[7]  = mk(1, 15,  3,  0, 8'h00, 0,   1, 15,  0, 8'h00, 0, 0, 1, 0); // boundary, max width
        tbl[8]  = mk(0,  0,  0,  1, 8'h7E, 0,   0, 15,  0, 8'h00, 0, 0, 1, 0); // LOAD again
        tbl[9]  = mk(0,  0,  0,  1, 8'h7F, 1,   0, 15,  1, 8'h7F, 0, 0, 1, 0); // first line pixel
        tbl[10] = mk(1,  3,  3,  0, 8'h00, 0,   0, 15,  0, 8'h00, 0, 0, 1, 1); // mid-frame reject
        tbl[11] = mk(1,  1,  3,  0, 8'h00, 0,   0, 15,  0, 8'h00, 0, 0, 1, 1);
        tbl[12] = mk(1, 16,  3,  0, 8'h00, 0,   0, 15,  0, 8'h00, 0, 0, 1, 1);
        tbl[13] = mk(0,  0,  0,  0, 8'h00, 0,   0, 15,  0, 8'h00, 0, 0, 1, 1); // err sticky

        do_reset();
        chk("reset_busy", dif.busy, 0);
        chk("reset_dly_val", dif.dly_val, 0);
        chk("reset_cfg_set", dif.dly_cfg_set, 0);
        chk("reset_cfg_err", dif.cfg_err, 0);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].cs, tbl[i].cw, tbl[i].ch, tbl[i].uv, tbl[i].ud, tbl[i].dv);
            chk($sformatf("v%0d_dly_cfg_set", i), dif.dly_cfg_set, tbl[i].e_cset);
            chk($sformatf("v%0d_dly_cfg_delay", i), dif.dly_cfg_delay, tbl[i].e_cdel);
            chk($sformatf("v%0d_dly_val", i), dif.dly_val, tbl[i].e_dval);
            if (tbl[i].e_dval) chk($sformatf("v%0d_dly_data", i), dif.dly_data, tbl[i].e_ddat);
            chk($sformatf("v%0d_win_val", i), dif.win_val, tbl[i].e_wval);
            chk($sformatf("v%0d_win_last", i), dif.win_last, tbl[i].e_wlast);
            chk($sformatf("v%0d_busy", i), dif.busy, tbl[i].e_busy);
            chk($sformatf("v%0d_cfg_err", i), dif.cfg_err, tbl[i].e_err);
        end

        // Configure 8x4 and stream one contiguous frame
        do_reset();
        step(1, 8, 4, 0, 0, 0);
        chk("cfg_dly_cfg_set", dif.dly_cfg_set, 1);
        chk("cfg_dly_cfg_delay", dif.dly_cfg_delay, 8);
        chk("cfg_busy", dif.busy, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("cfg_set_one_cycle", dif.dly_cfg_set, 0);
        wv_lo = 0; wv_hi = 0; wl_n = 0; wl_at = 0; dmis = 0;
        for (int i = 1; i <= 32; i++) begin
            step(0, 0, 0, 1, 8'(i), 1);
            if (dif.dly_val !== 1'b1 || dif.dly_data !== 8'(i)) dmis++;
            if (dif.win_val) begin
                if (i <= 16) wv_lo++;
                else wv_hi++;
            end
            if (dif.win_last) begin wl_n++; wl_at = i; end
        end
        chk("s1_win_val_first16", wv_lo, 0);
        chk("s1_win_val_last16", wv_hi, 16);
        chk("s1_win_last_count", wl_n, 1);
        chk("s1_win_last_pixel", wl_at, 32);
        chk("s1_forward_errors", dmis, 0);

        // Same frame with 5 idle cycles after every 8 pixels
        wv_hi = 0; wl_n = 0; spur = 0;
        for (int i = 1; i <= 32; i++) begin
            step(0, 0, 0, 1, 8'(i), 1);
            if (dif.win_val) wv_hi++;
            if (dif.win_last) wl_n++;
            if (i % 8 == 0) begin
                for (int g = 0; g < 5; g++) begin
                    step(0, 0, 0, 0, 0, 0);
                    if (dif.win_val || dif.win_last) spur++;
                end
            end
        end
        chk("s2_win_val_count", wv_hi, 16);
        chk("s2_win_last_count", wl_n, 1);
        chk("s2_spurious", spur, 0);
`ifdef DELAY_CTRL_FRAME_CNT_EN
        chk("s2_frame_cnt", frame_cnt, 2);
`endif

        // cfg_set mid-frame is rejected and the frame completes unchanged
        wv_hi = 0; wl_n = 0; wl_at = 0;
        for (int i = 1; i <= 32; i++) begin
            step(i == 10, 5, 3, 1, 8'(i), 1);
            if (i == 10) begin
                chk("s3_mid_cfg_err", dif.cfg_err, 1);
                chk("s3_mid_no_cfg_set", dif.dly_cfg_set, 0);
            end
            if (dif.win_val) wv_hi++;
            if (dif.win_last) begin wl_n++; wl_at = i; end
        end
        chk("s3_win_val_count", wv_hi, 16);
        chk("s3_win_last_pixel", wl_at, 32);
        step(1, 5, 3, 0, 0, 0);
        chk("s3_bound_cfg_set", dif.dly_cfg_set, 1);
        chk("s3_bound_delay", dif.dly_cfg_delay, 5);
        chk("s3_bound_cfg_err", dif.cfg_err, 0);
        step(0, 0, 0, 0, 0, 0);

        // New configuration on the last pixel of a 5x3 frame
        wv_hi = 0;
        for (int i = 1; i <= 15; i++) begin
            step(i == 15, 6, 4, 1, 8'(i), 1);
            if (dif.win_val) wv_hi++;
        end
        chk("s3b_win_val_count", wv_hi, 5);
        chk("s3b_win_last", dif.win_last, 1);
        chk("s3b_cfg_set", dif.dly_cfg_set, 1);
        chk("s3b_delay", dif.dly_cfg_delay, 6);
        chk("s3b_busy", dif.busy, 1);
`ifdef DELAY_CTRL_FRAME_CNT_EN
        chk("s3b_frame_cnt", frame_cnt, 4);
`endif
        step(0, 0, 0, 0, 0, 0);
        chk("s3b_cfg_set_drop", dif.dly_cfg_set, 0);

        // Asynchronous reset at pixel 20 of a 6x4 frame
        for (int i = 1; i <= 19; i++) step(0, 0, 0, 1, 8'(i), 1);
        set_in(0, 0, 0, 1, 8'd20, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_dly_val", dif.dly_val, 0);
        chk("r_dly_data", dif.dly_data, 0);
        chk("r_dly_cfg_delay", dif.dly_cfg_delay, 0);
        chk("r_dly_cfg_set", dif.dly_cfg_set, 0);
        chk("r_win_val", dif.win_val, 0);
        chk("r_win_last", dif.win_last, 0);
        chk("r_busy", dif.busy, 0);
        chk("r_cfg_err", dif.cfg_err, 0);
`ifdef DELAY_CTRL_FRAME_CNT_EN
        chk("r_frame_cnt", frame_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        spur = 0;
        for (int i = 21; i <= 30; i++) begin
            step(0, 0, 0, 1, 8'(i), 1);
            if (dif.dly_val || dif.win_val || dif.win_last || dif.busy || dif.dly_cfg_set) spur++;
        end
        chk("r_pixels_dropped", spur, 0);

        // Randomized traffic against the reference model
        do_reset();
        step(1, 8, 4, 0, 0, 0);
        check_model();
        for (int c = 0; c < 3000; c++) begin
            r_cs = ($urandom_range(0, 49) == 0) ||
                   (m_active && !m_loading && m_k == 0 && $urandom_range(0, 5) == 0);
            r_cw = 8'($urandom_range(0, 17));
            r_ch = 8'($urandom_range(1, 6));
            r_uv = 1'($urandom_range(0, 1));
            r_ud = 8'($urandom);
            r_dv = ($urandom_range(0, 9) < 7);
            step(r_cs, r_cw, r_ch, r_uv, r_ud, r_dv);
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
